matmul_ctrl: RTL and testbench

Sequencing controller for the matrix-multiply datapath (two operand RAMs, an 18-bit multiply-accumulate register and a result RAM). It first streams two DIM×DIM 8-bit operand matrices from `data_in` into the operand RAMs under a valid/ready handshake. It then walks every output element (i,j), issuing operand reads and MAC load pulses, and writes each accumulated sum into the result RAM. The controller sits beside the datapath at the top level and drives all of its enable, address and accumulator-control inputs.

---
 rtl/matmul_ctrl_pkg.sv | 26 ++
 rtl/matmul_idx_cnt.sv | 46 ++++
 rtl/matmul_ctrl.sv | 164 ++++++++++++++++
 tb/tb_matmul_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_ctrl_pkg.sv
// Shared types and sizing helpers for the matrix-multiply sequencing controller.
package matmul_ctrl_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ACC_W      = 2 * DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_CLEAR,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic int addr_w(input int m, input int n);
        return m + n;
    endfunction

    // Counter width for a 0..max-1 range, never narrower than one bit.
    function automatic int cnt_w(input int max);
        return (max > 1) ? $clog2(max) : 1;
    endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// Three-level (i,j,k) nested index counter; k is innermost and carries into j, then i.
module matmul_idx_cnt import matmul_ctrl_pkg::*; #(
    parameter int K_MAX = 4,
    parameter int J_MAX = 4,
    parameter int I_MAX = 4,
    parameter int KW    = cnt_w(K_MAX),
    parameter int JW    = cnt_w(J_MAX),
    parameter int IW    = cnt_w(I_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    output logic [KW-1:0] k,
    output logic [JW-1:0] j,
    output logic [IW-1:0] i,
    output logic          k_last,
    output logic          j_last,
    output logic          i_last
);

    assign k_last = (k == KW'(K_MAX - 1));
    assign j_last = (j == JW'(J_MAX - 1));
    assign i_last = (i == IW'(I_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            k <= '0;
            j <= '0;
            i <= '0;
        end else if (step) begin
            if (k_last) begin
                k <= '0;
                if (j_last) begin
                    j <= '0;
                    i <= i_last ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// Load/compute sequencer for the matmul datapath: streams A and B into the operand
// RAMs, then walks each C(i,j) with DIM+1 MAC phases followed by one write cycle.
module matmul_ctrl import matmul_ctrl_pkg::*; #(
    parameter int DIM = 4,
    parameter int m   = 8,
    parameter int n   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   m1EN,
    output logic                   m1rEN,
    output logic                   m1wEN,
    output logic                   m2EN,
    output logic                   m2rEN,
    output logic                   m2wEN,
    output logic                   m3EN,
    output logic                   m3rEN,
    output logic                   m3wEN,
    output logic                   mult_ld,
    output logic                   mult_rst,
    output logic [addr_w(m,n)-1:0] addr1,
    output logic [addr_w(m,n)-1:0] addr2,
    output logic [addr_w(m,n)-1:0] addr3
);

    localparam int AW     = addr_w(m, n);
    localparam int LD_MAX = DIM * DIM;
    localparam int LW     = cnt_w(LD_MAX);
    localparam int PH_MAX = DIM + 2;
    localparam int PW     = cnt_w(PH_MAX);
    localparam int IW     = cnt_w(DIM);

    state_t state, state_next;

    logic [LW-1:0] ld_idx;
    logic [0:0]    ld_j, ld_i;
    logic          ld_last, ld_j_last, ld_i_last, ld_step;

    logic [PW-1:0] ph;
    logic [IW-1:0] ci, cj;
    logic          ph_last, cj_last, ci_last, cnt_step;

    logic [AW-1:0] row_base, a_idx, b_idx, c_idx;

    assign ld_step  = in_valid && (state == S_LOAD_A || state == S_LOAD_B);
    assign cnt_step = (state == S_MAC) || (state == S_WRITE);

    // Load counter: one flat level covering all DIM*DIM words, shared by A and B.
    matmul_idx_cnt #(.K_MAX(LD_MAX), .J_MAX(1), .I_MAX(1)) u_ld_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == S_IDLE),
        .step   (ld_step),
        .k      (ld_idx),
        .j      (ld_j),
        .i      (ld_i),
        .k_last (ld_last),
        .j_last (ld_j_last),
        .i_last (ld_i_last)
    );

    // Compute counter: k runs DIM MAC read phases, one drain phase, then the WRITE
    // phase, whose wrap carries j (and i) forward exactly as the write completes.
    matmul_idx_cnt #(.K_MAX(PH_MAX), .J_MAX(DIM), .I_MAX(DIM)) u_mac_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == S_CLEAR),
        .step   (cnt_step),
        .k      (ph),
        .j      (cj),
        .i      (ci),
        .k_last (ph_last),
        .j_last (cj_last),
        .i_last (ci_last)
    );

    logic unused_flags;
    assign unused_flags = ^{ld_j, ld_i, ld_j_last, ld_i_last, ph_last};

    assign row_base = AW'(ci) * AW'(DIM);
    assign a_idx    = row_base + AW'(ph);
    assign b_idx    = AW'(ph) * AW'(DIM) + AW'(cj);
    assign c_idx    = row_base + AW'(cj);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        m1EN       = 1'b0;
        m1rEN      = 1'b0;
        m1wEN      = 1'b0;
        m2EN       = 1'b0;
        m2rEN      = 1'b0;
        m2wEN      = 1'b0;
        m3EN       = 1'b0;
        m3rEN      = 1'b0;
        m3wEN      = 1'b0;
        mult_ld    = 1'b0;
        mult_rst   = 1'b0;
        addr1      = '0;
        addr2      = '0;
        addr3      = '0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                m1EN     = in_valid;
                m1wEN    = in_valid;
                addr1    = AW'(ld_idx);
                if (in_valid && ld_last) state_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                m2EN     = in_valid;
                m2wEN    = in_valid;
                addr2    = AW'(ld_idx);
                if (in_valid && ld_last) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                mult_rst   = 1'b1;
                state_next = S_MAC;
            end
            S_MAC: begin
                // Reads lead the accumulate by one phase to cover RAM read latency.
                if (ph < PW'(DIM)) begin
                    m1EN  = 1'b1;
                    m1rEN = 1'b1;
                    m2EN  = 1'b1;
                    m2rEN = 1'b1;
                    addr1 = a_idx;
                    addr2 = b_idx;
                end
                mult_ld = (ph != '0);
                if (ph == PW'(DIM)) state_next = S_WRITE;
            end
            S_WRITE: begin
                m3EN       = 1'b1;
                m3wEN      = 1'b1;
                addr3      = c_idx;
                mult_rst   = 1'b1;
                state_next = (ci_last && cj_last) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl with a behavioural RAM/MAC datapath model around it.
module tb_matmul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic        in_ready, busy, done;
    logic        m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN, m3EN, m3rEN, m3wEN;
    logic        mult_ld, mult_rst;
    logic [15:0] addr1, addr2, addr3;

    matmul_ctrl #(.DIM(4), .m(8), .n(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done),
        .m1EN(m1EN), .m1rEN(m1rEN), .m1wEN(m1wEN),
        .m2EN(m2EN), .m2rEN(m2rEN), .m2wEN(m2wEN),
        .m3EN(m3EN), .m3rEN(m3rEN), .m3wEN(m3wEN),
        .mult_ld(mult_ld), .mult_rst(mult_rst),
        .addr1(addr1), .addr2(addr2), .addr3(addr3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int hs_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ctl bits: in_ready busy done m1EN m1rEN m1wEN m2EN m2rEN m2wEN m3EN m3rEN m3wEN mult_ld mult_rst
    logic [13:0] ctl;
    assign ctl = {in_ready, busy, done, m1EN, m1rEN, m1wEN, m2EN, m2rEN, m2wEN,
                  m3EN, m3rEN, m3wEN, mult_ld, mult_rst};

    // Datapath model: 1-cycle read RAMs, 18-bit accumulator, result RAM.
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];
    logic [17:0] mem_c [256];
    logic [7:0]  rd1 = 8'd0;
    logic [7:0]  rd2 = 8'd0;
    logic [17:0] acc = 18'd0;
    logic        wipe = 1'b0;

    always @(posedge clk) begin
        if (rst || mult_rst) acc <= 18'd0;
        else if (mult_ld)    acc <= acc + ({10'd0, rd1} * {10'd0, rd2});
        if (m1EN && m1wEN) mem_a[addr1[7:0]] <= data_in;
        if (m1EN && m1rEN) rd1 <= mem_a[addr1[7:0]];
        if (m2EN && m2wEN) mem_b[addr2[7:0]] <= data_in;
        if (m2EN && m2rEN) rd2 <= mem_b[addr2[7:0]];
        if (wipe) begin
            for (int q = 0; q < 256; q++) mem_c[q] <= 18'h3FFFF;
        end else if (m3EN && m3wEN) begin
            mem_c[addr3[7:0]] <= acc;
        end
    end

    // Log of operand-RAM writes during a run: {is_B, address}.
    logic [16:0] ld_log [64];
    int ld_n = 0;
    always @(negedge clk) begin
        if (!busy) ld_n = 0;
        else if ((m1EN && m1wEN) || (m2EN && m2wEN)) begin
            if (ld_n < 64) ld_log[ld_n] = {m2EN & m2wEN, (m1EN && m1wEN) ? addr1 : addr2};
            ld_n++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic feed(input logic [7:0] w [32], input bit stall, input bit poke);
        int idx = 0;
        int gap = 0;
        int guard = 0;
        while (idx < 32 && guard < 500) begin
            @(negedge clk);
            guard++;
            start = poke && (idx == 20);
            if (gap > 0) begin
                in_valid = 1'b0;
                gap--;
            end else begin
                in_valid = 1'b1;
                data_in  = w[idx];
                if (in_ready) begin
                    idx++;
                    if (idx == 32) hs_cyc = cyc + 1;
                    else if (stall && (idx % 3 == 0)) gap = 2;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        chk("feed_words", 64'(idx), 64'd32);
        chk("clear_ctl", 64'(ctl), 64'h1001);
    endtask

    task automatic run(input logic [7:0] a [16], input logic [7:0] b [16],
                       input bit stall, input bit poke, input logic [17:0] ce [16]);
        logic [7:0] w [32];
        int guard = 0;
        int n_ld = 0;
        int extra = 0;
        bit got = 1'b0;
        for (int r = 0; r < 16; r++) begin
            w[r]      = a[r];
            w[16 + r] = b[r];
        end
        wipe = 1'b1;
        @(negedge clk);
        wipe  = 1'b0;
        start = 1'b1;
        feed(w, stall, poke);
        while (!got && guard < 400) begin
            @(negedge clk);
            guard++;
            start = poke && (cyc == hs_cyc + 20);
            // element (0,3), phase 1: reads of A[0][1], B[1][3] plus first accumulate
            if (cyc == hs_cyc + 20) begin
                chk("mac_ctl", 64'(ctl), 64'h16C2);
                chk("mac_addr1", 64'(addr1), 64'd1);
                chk("mac_addr2", 64'(addr2), 64'd7);
            end
            if (done) begin
                got  = 1'b1;
                n_ld = ld_n;
            end
        end
        start = 1'b0;
        chk("done_latency", got ? 64'(cyc - hs_cyc) : 64'hFFFF, 64'd97);
        @(negedge clk);
        chk("done_pulse", 64'({done, busy}), 64'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("extra_done", 64'(extra), 64'd0);
        chk("ld_count", 64'(n_ld), 64'd32);
        for (int q = 0; q < 32; q++)
            chk("ld_seq", 64'(ld_log[q]), 64'((q / 16) * 65536 + (q % 16)));
        for (int r = 0; r < 16; r++)
            chk("result", 64'(mem_c[r]), 64'(ce[r]));
    endtask

    logic [7:0]  a_id [16], a_2i [16], a_seq [16], a_max [16];
    logic [17:0] c_seq [16], c_2seq [16], c_max [16];

    initial begin
        for (int r = 0; r < 16; r++) begin
            a_id[r]   = (r % 5 == 0) ? 8'd1 : 8'd0;
            a_2i[r]   = (r % 5 == 0) ? 8'd2 : 8'd0;
            a_seq[r]  = 8'(r + 1);
            a_max[r]  = 8'd255;
            c_seq[r]  = 18'(r + 1);
            c_2seq[r] = 18'(2 * (r + 1));
            c_max[r]  = 18'h3F804;
        end

        repeat (3) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_out", {2'b00, ctl, addr1, addr2, addr3}, 64'd0);
        end
        in_valid = 1'b0;

        run(a_id, a_seq, 1'b0, 1'b0, c_seq);
        run(a_max, a_max, 1'b0, 1'b0, c_max);
        run(a_seq, a_id, 1'b1, 1'b0, c_seq);

        // abort during element (2,1), phase 2
        @(negedge clk);
        start = 1'b1;
        begin
            logic [7:0] w [32];
            for (int r = 0; r < 16; r++) begin
                w[r]      = a_id[r];
                w[16 + r] = a_seq[r];
            end
            feed(w, 1'b0, 1'b0);
        end
        while (cyc < hs_cyc + 57) @(negedge clk);
        chk("mid_addr1", 64'(addr1), 64'd10);
        chk("mid_addr2", 64'(addr2), 64'd9);
        chk("mid_ld", 64'(mult_ld), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", {2'b00, ctl, addr1, addr2, addr3}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 64'(ctl), 64'd0);

        run(a_id, a_seq, 1'b0, 1'b0, c_seq);
        run(a_2i, a_seq, 1'b0, 1'b1, c_2seq);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
